bsg_bladerunner_rom_banked: RTL
===============================

Name: bsg_bladerunner_rom_banked

Overview:
Next-generation read-only configuration ROM slave. It sits behind a bsg_manycore_endpoint_standard instance, on the endpoint's in_*/returning_* side.
- Generalises the ROM width: entries may be up to words_p manycore words wide, and low address bits select the word within an entry.
- Adds response buffering with backpressure.
- Adds out-of-range and write detection with sticky error reporting instead of simulation-only termination.
- ROM contents are supplied externally through a combinational lookup port, so any generated configuration table can be attached.

Parameters:
data_width_p, 32, manycore link data width; must be a multiple of 8.
addr_width_p, 28, manycore EPA address width.
rom_els_p, 64, number of ROM entries.
words_p, 2, data_width_p-sized words per ROM entry; power of 2, at least 1.
rom_width_p, 64, ROM entry width; must be at most words_p*data_width_p, and is zero-extended up to that.
resp_els_p, 4, response buffer depth, which is also the maximum number of outstanding reads; at least 2.
err_cnt_width_p, 8, width of the saturating error counter.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
in_v_i  in  1  request valid from endpoint
in_yumi_o  out  1  request consumed
in_we_i  in  1  request is a write
in_addr_i  in  addr_width_p  word address
in_mask_i  in  data_width_p/8  byte mask
rom_addr_o  out  clog2(rom_els_p)  lookup index to the external ROM table
rom_data_i  in  rom_width_p  combinational ROM data for rom_addr_o
returning_v_o  out  1  read response valid
returning_data_o  out  data_width_p  read response data
returning_ready_i  in  1  endpoint accepts the response
err_o  out  1  sticky flag: a write or out-of-range access has occurred
err_cnt_o  out  err_cnt_width_p  saturating count of error events
err_clr_i  in  1  synchronous clear of err_o and err_cnt_o

Behaviour:
Reset:
- Asynchronous assert, synchronous deassert handled externally.
- While reset_n_i=0: in_yumi_o=0, returning_v_o=0, returning_data_o=0, err_o=0, err_cnt_o=0.
- Buffer is empty, outstanding counter is 0, pipeline valid bit is 0.
- Reset mid-operation discards all in-flight responses.

Address decode (lg_w = clog2(words_p), 0 when words_p=1):
- word_sel = in_addr_i[lg_w-1:0].
- entry = in_addr_i[lg_w +: clog2(rom_els_p)].
- rom_addr_o = entry, driven combinationally from in_addr_i.
- Out-of-range when any in_addr_i bit above the entry field is 1, or when entry >= rom_els_p.

Acceptance:
- outstanding = pipeline-valid + buffer occupancy, never exceeding resp_els_p.
- Writes are always accepted: in_yumi_o = in_v_i & in_we_i.
- Reads are accepted when outstanding < resp_els_p, or when outstanding = resp_els_p and a buffer pop occurs in the same cycle.
- Combined: in_yumi_o = in_v_i & (in_we_i | read_ok).

Read pipeline:
- Cycle N (accept): the selected word of zero-extended rom_data_i is registered, with each byte i ANDed with in_mask_i[i], into a one-stage pipeline register.
- Out-of-range reads register data 0.
- Cycle N+1: the pipeline register is enqueued into the buffer.
- returning_v_o is asserted no earlier than cycle N+1; the buffer is first-word fall-through so the registered entry is visible the same cycle.
- The buffer pops when returning_v_o & returning_ready_i.
- Responses are delivered strictly in acceptance order.
- Sustained throughput is 1 read per cycle while returning_ready_i=1.

Writes:
- Writes produce no response and are dropped.
- An accepted write is an error event.

Errors:
- Each accepted write and each accepted out-of-range read is one error event.
- An error event sets err_o and increments err_cnt_o, saturating at all-ones.
- err_clr_i has priority over an error event in the same cycle: the result is 0.

Simultaneous enqueue and pop at full:
- Allowed; occupancy is unchanged.

Decomposition:
- Shared package bsg_bladerunner_rom_pkg holds:
  - the localparam helpers for lg_w and the ROM address width;
  - an error-cause enum (e_err_write, e_err_range) used by the bench.
- One natural sub-module: the response buffer. Use the existing bsg_fifo_1r1w_small with els_p=resp_els_p; no new sub-module is required.
- The surrounding wrapper that binds this block to bsg_manycore_endpoint_standard lives outside this module.

Test Plan:
1. Linear reads: words_p=2, entry 3 = 64'h1122334455667788, returning_ready_i=1. Read addr 6 returns 32'h55667788; read addr 7 returns 32'h11223344. Each response appears 1 cycle after yumi, back-to-back.
2. Byte mask: read addr 6 with in_mask_i=4'b0101 returns 32'h00660088.
3. Backpressure: returning_ready_i=0 with 6 reads offered and resp_els_p=4. Exactly 4 yumis occur, then in_yumi_o=0. Raising ready drains 4 responses in order, then accepts the remaining 2.
4. Out-of-range: rom_els_p=64, read addr 128 (entry 64) returns 0, err_o=1, err_cnt_o=1. Read addr 0x1000000 behaves the same and gives err_cnt_o=2.
5. Write and saturation: 300 writes give yumi each cycle, no returning_v_o, err_cnt_o=255. err_clr_i coincident with a write gives err_cnt_o=0 and err_o=0.
6. Reset mid-stream: with 3 responses buffered, pulse reset_n_i low asynchronously between edges. Outputs go to 0 immediately and no stale response appears after reset.

Source files
------------

// File: rtl/bsg_bladerunner_rom_pkg.sv
// Shared helpers for the banked configuration ROM slave: address-field widths and
// the error-cause encoding.
package bsg_bladerunner_rom_pkg;

    typedef enum logic [0:0] {
        e_err_write,
        e_err_range
    } err_cause_e;

    localparam int unsigned byte_width_lp = 8;

    // Number of low address bits that pick a word within one ROM entry.
    function automatic int unsigned lg_words_f(input int unsigned words);
        return (words > 1) ? $clog2(words) : 0;
    endfunction

    function automatic int unsigned rom_addr_width_f(input int unsigned els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small first-word-fall-through FIFO with asynchronous active-low reset. A push is
// accepted while full if a pop happens in the same cycle.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_full;
    logic                w_enq;
    logic                w_deq;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign w_full  = (r_count == cnt_w_lp'(els_p));
    assign v_o     = (r_count != '0);
    assign ready_o = ~w_full | yumi_i;
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_deq) r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + cnt_w_lp'(w_enq) - cnt_w_lp'(w_deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/bsg_bladerunner_rom_banked.sv
// Read-only configuration ROM slave for the manycore endpoint: multi-word entries,
// buffered in-order responses with backpressure, sticky write/out-of-range errors.
module bsg_bladerunner_rom_banked
    import bsg_bladerunner_rom_pkg::*;
#(
    parameter int unsigned data_width_p    = 32,
    parameter int unsigned addr_width_p    = 28,
    parameter int unsigned rom_els_p       = 64,
    parameter int unsigned words_p         = 2,
    parameter int unsigned rom_width_p     = 64,
    parameter int unsigned resp_els_p      = 4,
    parameter int unsigned err_cnt_width_p = 8
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    in_v_i,
    output logic                                    in_yumi_o,
    input  logic                                    in_we_i,
    input  logic [addr_width_p-1:0]                 in_addr_i,
    input  logic [data_width_p/8-1:0]               in_mask_i,
    output logic [rom_addr_width_f(rom_els_p)-1:0]  rom_addr_o,
    input  logic [rom_width_p-1:0]                  rom_data_i,
    output logic                                    returning_v_o,
    output logic [data_width_p-1:0]                 returning_data_o,
    input  logic                                    returning_ready_i,
    output logic                                    err_o,
    output logic [err_cnt_width_p-1:0]              err_cnt_o,
    input  logic                                    err_clr_i
);
    localparam int unsigned lg_w_lp     = lg_words_f(words_p);
    localparam int unsigned rom_aw_lp   = rom_addr_width_f(rom_els_p);
    localparam int unsigned sel_w_lp    = (lg_w_lp > 0) ? lg_w_lp : 1;
    localparam int unsigned entry_w_lp  = words_p * data_width_p;
    localparam int unsigned bytes_lp    = data_width_p / byte_width_lp;
    localparam int unsigned cnt_w_lp    = $clog2(resp_els_p + 1);
    localparam int unsigned hi_shift_lp = lg_w_lp + rom_aw_lp;

    logic [sel_w_lp-1:0]        w_word_sel;
    logic [rom_aw_lp-1:0]       w_entry;
    logic [addr_width_p-1:0]    w_addr_hi;
    logic                       w_entry_oor;
    logic                       w_oor;
    logic [entry_w_lp-1:0]      w_rom_ext;
    logic [data_width_p-1:0]    w_word;
    logic [data_width_p-1:0]    w_masked;

    logic                       w_pop;
    logic                       w_read_ok;
    logic                       w_acc_rd;
    logic                       w_err_evt;
    logic [cnt_w_lp-1:0]        r_outstanding;

    logic                       r_pipe_v;
    logic [data_width_p-1:0]    r_pipe_data;
    logic                       w_fifo_v;
    logic                       w_fifo_ready;
    logic [data_width_p-1:0]    w_fifo_data;
    logic                       w_enq;
    logic                       w_deq;

    logic                       r_err;
    logic [err_cnt_width_p-1:0] r_err_cnt;

    if (lg_w_lp > 0) begin : g_word_sel
        assign w_word_sel = in_addr_i[sel_w_lp-1:0];
    end else begin : g_single_word
        assign w_word_sel = '0;
    end

    if (rom_els_p == (1 << rom_aw_lp)) begin : g_full_table
        assign w_entry_oor = 1'b0;
    end else begin : g_partial_table
        assign w_entry_oor = (w_entry >= rom_aw_lp'(rom_els_p));
    end

    assign w_entry    = in_addr_i[lg_w_lp +: rom_aw_lp];
    assign w_addr_hi  = in_addr_i >> hi_shift_lp;
    assign w_oor      = (w_addr_hi != '0) | w_entry_oor;
    assign rom_addr_o = w_entry;

    assign w_rom_ext = entry_w_lp'(rom_data_i);
    assign w_word    = w_rom_ext[w_word_sel*data_width_p +: data_width_p];

    always_comb begin
        w_masked = '0;
        for (int i = 0; i < bytes_lp; i++) begin
            w_masked[i*byte_width_lp +: byte_width_lp] =
                w_word[i*byte_width_lp +: byte_width_lp] & {byte_width_lp{in_mask_i[i]}};
        end
    end

    // Outstanding covers the pipeline stage plus buffered entries; a same-cycle pop
    // frees a slot so a full slave can still stream.
    assign w_pop     = returning_v_o & returning_ready_i;
    assign w_read_ok = (r_outstanding < cnt_w_lp'(resp_els_p)) | w_pop;
    assign in_yumi_o = reset_n_i & in_v_i & (in_we_i | w_read_ok);
    assign w_acc_rd  = in_yumi_o & ~in_we_i;
    assign w_err_evt = in_yumi_o & (in_we_i | w_oor);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_outstanding <= '0;
            r_pipe_v      <= 1'b0;
            r_pipe_data   <= '0;
        end else begin
            r_outstanding <= r_outstanding + cnt_w_lp'(w_acc_rd) - cnt_w_lp'(w_pop);
            r_pipe_v      <= w_acc_rd;
            if (w_acc_rd) r_pipe_data <= w_oor ? '0 : w_masked;
        end
    end

    // With an empty buffer the pipeline entry is presented directly and only
    // enqueued if the endpoint does not take it this cycle.
    assign w_enq = r_pipe_v & ~(~w_fifo_v & returning_ready_i);
    assign w_deq = w_fifo_v & returning_ready_i;

    assign returning_v_o    = w_fifo_v | r_pipe_v;
    assign returning_data_o = w_fifo_v ? w_fifo_data : (r_pipe_v ? r_pipe_data : '0);

    bsg_fifo_1r1w_small #(
        .width_p (data_width_p),
        .els_p   (resp_els_p)
    ) resp_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (w_enq & w_fifo_ready),
        .ready_o   (w_fifo_ready),
        .data_i    (r_pipe_data),
        .v_o       (w_fifo_v),
        .data_o    (w_fifo_data),
        .yumi_i    (w_deq)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (err_clr_i) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + err_cnt_width_p'(1);
        end
    end

    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;

endmodule
